// File: rtl/imem_pkg.sv
// Shared constants and helpers for the synchronous instruction memory.
package imem_pkg;

  localparam int unsigned DEF_DATA_W = 32;
  localparam int unsigned DEF_DEPTH  = 64;
  localparam int unsigned DEF_ADDR_W = 32;

  // addi x0,x0,0: fill, reset and fault value
  localparam logic [31:0] NOP_INSN = 32'h00000013;

  function automatic int unsigned index_w(input int unsigned depth);
    return $clog2(depth);
  endfunction

endpackage

// File: rtl/imem_array.sv
// DEPTH x DATA_W storage: one synchronous write port, one registered read port
// with enable and a synchronous clear-to-fill on the read register.
module imem_array
  import imem_pkg::*;
#(
  parameter int unsigned       DATA_W = DEF_DATA_W,
  parameter int unsigned       DEPTH  = DEF_DEPTH,
  parameter int unsigned       IW     = index_w(DEPTH),
  parameter logic [DATA_W-1:0] FILL   = DATA_W'(NOP_INSN)
) (
  input  logic              clk,
  input  logic              i_we,
  input  logic [IW-1:0]     i_waddr,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic              i_rd_en,
  input  logic              i_rd_clr,
  input  logic [IW-1:0]     i_raddr,
  output logic [DATA_W-1:0] o_rd_data
);

  logic [DATA_W-1:0] r_mem [DEPTH] = '{default: FILL};
  logic [DATA_W-1:0] r_rd_data;

  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  // Clear has priority so reset/flush/fault always leave the fill word behind
  always_ff @(posedge clk) begin
    if (i_rd_clr) begin
      r_rd_data <= FILL;
    end else if (i_rd_en) begin
      r_rd_data <= r_mem[i_raddr];
    end
  end

  assign o_rd_data = r_rd_data;

endmodule

// File: rtl/imem_sync.sv
// Synchronous instruction memory: valid/ready fetch with 1-cycle latency,
// flush, program-load port. Optional IMEM_FAULT_EN flags misaligned/out-of-range fetches.
module imem_sync
  import imem_pkg::*;
#(
  parameter int unsigned       DATA_W = DEF_DATA_W,
  parameter int unsigned       DEPTH  = DEF_DEPTH,
  parameter int unsigned       ADDR_W = DEF_ADDR_W,
  parameter logic [DATA_W-1:0] NOP    = DATA_W'(NOP_INSN)
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      req_valid,
  output logic                      req_ready,
  input  logic [ADDR_W-1:0]         req_addr,
  output logic                      rsp_valid,
  input  logic                      rsp_ready,
  output logic [DATA_W-1:0]         rsp_data,
  output logic                      rsp_fault,
  input  logic                      flush,
  input  logic                      prog_en,
  input  logic                      prog_we,
  input  logic [index_w(DEPTH)-1:0] prog_addr,
  input  logic [DATA_W-1:0]         prog_data
);

  localparam int unsigned IW = index_w(DEPTH);

  logic          r_rsp_valid;
  logic          w_accept;
  logic          w_fault;
  logic          w_rd_en;
  logic          w_rd_clr;
  logic          w_we;
  logic [IW-1:0] w_index;

  assign req_ready = !reset && !prog_en && !flush && (!r_rsp_valid || rsp_ready);
  assign w_accept  = req_valid && req_ready;
  assign w_index   = req_addr[IW+1:2];

`ifdef IMEM_FAULT_EN
  logic r_rsp_fault;

  assign w_fault = (req_addr[1:0] != 2'b00) || (req_addr >= ADDR_W'(DEPTH * 4));

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      r_rsp_fault <= 1'b0;
    end else if (w_accept) begin
      r_rsp_fault <= w_fault;
    end
  end

  assign rsp_fault = r_rsp_fault;
`else
  // Without fault checking the address wraps; the dropped bits are deliberately unused
  logic w_unused;
  assign w_unused  = ^{req_addr[ADDR_W-1:IW+2], req_addr[1:0]};
  assign w_fault   = 1'b0;
  assign rsp_fault = 1'b0;
`endif

  assign w_rd_en  = w_accept && !w_fault;
  assign w_rd_clr = reset || flush || (w_accept && w_fault);
  assign w_we     = prog_en && prog_we && !reset;

  // Flush/reset drop the response; an accept refills it; a handshake alone empties it
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      r_rsp_valid <= 1'b0;
    end else if (w_accept) begin
      r_rsp_valid <= 1'b1;
    end else if (rsp_ready) begin
      r_rsp_valid <= 1'b0;
    end
  end

  assign rsp_valid = r_rsp_valid;

  imem_array #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .IW     (IW),
    .FILL   (NOP)
  ) u_array (
    .clk       (clk),
    .i_we      (w_we),
    .i_waddr   (prog_addr),
    .i_wdata   (prog_data),
    .i_rd_en   (w_rd_en),
    .i_rd_clr  (w_rd_clr),
    .i_raddr   (w_index),
    .o_rd_data (rsp_data)
  );

endmodule

// File: tb/tb_imem_sync.sv
// Directed self-checking bench for imem_sync (default parameters).
module tb_imem_sync;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned DEPTH  = 64;
  localparam int unsigned ADDR_W = 32;
  localparam logic [31:0] NOP    = 32'h00000013;

  logic              clk = 1'b0;
  logic              reset;
  logic              req_valid;
  logic              req_ready;
  logic [ADDR_W-1:0] req_addr;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [DATA_W-1:0] rsp_data;
  logic              rsp_fault;
  logic              flush;
  logic              prog_en;
  logic              prog_we;
  logic [5:0]        prog_addr;
  logic [DATA_W-1:0] prog_data;

  int checks = 0;
  int errors = 0;

  logic [31:0] prog_words [4] = '{32'h02328020, 32'h00000093, 32'h00100113, 32'h002081B3};

  always #5 clk = ~clk;

  imem_sync #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W),
    .NOP    (NOP)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_addr  (req_addr),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
    .rsp_fault (rsp_fault),
    .flush     (flush),
    .prog_en   (prog_en),
    .prog_we   (prog_we),
    .prog_addr (prog_addr),
    .prog_data (prog_data)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  // Advance one edge; inputs are driven and outputs sampled at the falling edge
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    reset = 1'b1; req_valid = 1'b0; req_addr = '0; rsp_ready = 1'b0; flush = 1'b0;
    prog_en = 1'b0; prog_we = 1'b0; prog_addr = '0; prog_data = '0;
    tick(); tick();
    #1;
    check("rst_valid", 32'(rsp_valid), 32'd0);
    check("rst_data",  rsp_data, NOP);
    check("rst_fault", 32'(rsp_fault), 32'd0);
    check("rst_ready", 32'(req_ready), 32'd0);

    // Program words 0..3
    reset = 1'b0; prog_en = 1'b1; prog_we = 1'b1; req_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      prog_addr = 6'(i); prog_data = prog_words[i];
      #1 check("prog_ready", 32'(req_ready), 32'd0);
      tick();
    end
    prog_en = 1'b0; prog_we = 1'b0;

    // Back-to-back fetch, one word per cycle
    rsp_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      req_addr = 32'(i * 4);
      tick();
      check("b2b_valid", 32'(rsp_valid), 32'd1);
      check("b2b_data",  rsp_data, prog_words[i]);
    end
    req_valid = 1'b0;
    tick();
    check("b2b_drain", 32'(rsp_valid), 32'd0);

    // Backpressure holds the response
    rsp_ready = 1'b0; req_valid = 1'b1; req_addr = 32'h4;
    tick();
    req_addr = 32'h8;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("hold_ready", 32'(req_ready), 32'd0);
      check("hold_valid", 32'(rsp_valid), 32'd1);
      check("hold_data",  rsp_data, 32'h00000093);
      tick();
    end
    req_valid = 1'b0; rsp_ready = 1'b1;
    #1 check("hold_rdy_up", 32'(req_ready), 32'd1);
    tick();
    check("hold_done", 32'(rsp_valid), 32'd0);

    // Flush drops a pending response and blocks the concurrent request
    rsp_ready = 1'b0; req_valid = 1'b1; req_addr = 32'hC;
    tick();
    check("fl_pend", rsp_data, 32'h002081B3);
    flush = 1'b1; req_addr = 32'h0;
    #1 check("fl_ready", 32'(req_ready), 32'd0);
    tick();
    flush = 1'b0; req_valid = 1'b0;
    check("fl_valid", 32'(rsp_valid), 32'd0);
    check("fl_data",  rsp_data, NOP);
    tick();
    check("fl_noacc", 32'(rsp_valid), 32'd0);

    // Programming with a response pending
    req_valid = 1'b1; req_addr = 32'h8;
    tick();
    req_valid = 1'b0; prog_en = 1'b1; prog_we = 1'b1; prog_addr = 6'd1; prog_data = 32'hDEADBEEF;
    tick();
    check("pp_valid", 32'(rsp_valid), 32'd1);
    check("pp_data",  rsp_data, 32'h00100113);
    prog_en = 1'b0; prog_we = 1'b0; rsp_ready = 1'b1;
    tick();
    check("pp_consume", 32'(rsp_valid), 32'd0);
    req_valid = 1'b1; req_addr = 32'h4;
    tick();
    check("pp_new", rsp_data, 32'hDEADBEEF);

    // Unwritten word reads the fill value
    req_addr = 32'h28;
    tick();
    check("fill_data", rsp_data, NOP);
    check("fill_fault", 32'(rsp_fault), 32'd0);

    // Out-of-range and misaligned addresses
    req_addr = 32'(DEPTH * 4);
    tick();
`ifdef IMEM_FAULT_EN
    check("oor_data",  rsp_data, NOP);
    check("oor_fault", 32'(rsp_fault), 32'd1);
`else
    check("oor_data",  rsp_data, 32'h02328020);
    check("oor_fault", 32'(rsp_fault), 32'd0);
`endif
    req_addr = 32'h2;
    tick();
`ifdef IMEM_FAULT_EN
    check("mis_data",  rsp_data, NOP);
    check("mis_fault", 32'(rsp_fault), 32'd1);
`else
    check("mis_data",  rsp_data, 32'h02328020);
    check("mis_fault", 32'(rsp_fault), 32'd0);
`endif

    // Reset mid-stream; write attempted during reset must be ignored
    req_addr = 32'hC; rsp_ready = 1'b0;
    tick();
    check("mr_valid_pre", 32'(rsp_valid), 32'd1);
    req_valid = 1'b0; reset = 1'b1;
    prog_en = 1'b1; prog_we = 1'b1; prog_addr = 6'd0; prog_data = 32'hFFFFFFFF;
    #1 check("mr_ready", 32'(req_ready), 32'd0);
    tick();
    check("mr_valid", 32'(rsp_valid), 32'd0);
    check("mr_data",  rsp_data, NOP);
    check("mr_fault", 32'(rsp_fault), 32'd0);
    reset = 1'b0; prog_en = 1'b0; prog_we = 1'b0;
    req_valid = 1'b1; rsp_ready = 1'b1; req_addr = 32'h0;
    #1 check("mr_ready_up", 32'(req_ready), 32'd1);
    tick();
    check("mr_keep0", rsp_data, 32'h02328020);
    req_addr = 32'hC;
    tick();
    check("mr_keep3", rsp_data, 32'h002081B3);
    req_valid = 1'b0;
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/imem_sync.md
# imem_sync

Parametrised synchronous instruction memory for the RISC-V core's fetch stage. It replaces the fixed 32-entry combinational ROM with a configurable-depth array. Fetches use a valid/ready request/response handshake with one cycle of read latency, a flush input, and a program-load port. It sits between the PC/fetch unit and the decode stage.

## Interface
- `DATA_W`, 32: instruction word width in bits.
- `DEPTH`, 64: number of words; must be a power of 2 and at least 2.
- `ADDR_W`, 32: byte-address width of `req_addr`.
- `NOP`, 32'h00000013: `addi x0,x0,0`; used as the fill, reset and fault value.
- `clk`  in  1  single clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `req_valid`  in  1  fetch request present.
- `req_ready`  out  1  request accepted this cycle when `req_valid & req_ready`.
- `req_addr`  in  ADDR_W  byte address of the instruction.
- `rsp_valid`  out  1  response holds a fetched word.
- `rsp_ready`  in  1  consumer takes the response.
- `rsp_data`  out  DATA_W  fetched instruction.
- `rsp_fault`  out  1  fetch was misaligned or out of range (only with `IMEM_FAULT_EN`).
- `flush`  in  1  discard any pending response.
- `prog_en`  in  1  program mode; fetch is blocked while high.
- `prog_we`  in  1  write strobe, honoured only when `prog_en` is high.
- `prog_addr`  in  $clog2(DEPTH)  word index to write.
- `prog_data`  in  DATA_W  word to write.

## Operation
- Word index is `req_addr[$clog2(DEPTH)+1:2]`.
- `req_ready = !reset & !prog_en & !flush & (!rsp_valid | rsp_ready)`.
- On an accepted request, the response register loads `mem[index]` and `rsp_valid` is 1 on the next cycle.
- While `rsp_valid & !rsp_ready`, `rsp_data` and `rsp_fault` hold stable.
- Response bookkeeping:
  - `rsp_valid` clears after a handshake unless a new request is accepted in the same cycle.
  - Back-to-back accepts give one word per cycle.
- Flush:
  - `rsp_valid` is 0 on the next edge, and the consumer must not complete a handshake in the flush cycle.
  - `rsp_data` takes `NOP`.
  - Flush beats `rsp_ready` and blocks new accepts in the same cycle.
- Program mode:
  - With `prog_en & prog_we`, `mem[prog_addr] <= prog_data` at the edge.
  - A response already pending stays valid and unchanged until consumed or flushed.
- Reset:
  - Outputs after reset: `rsp_valid=0`, `rsp_data=NOP`, `rsp_fault=0`, `req_ready=0` during reset.
  - Memory contents are not reset; at time zero every word is `NOP`.
  - Reset mid-response drops the response.
- Writes during reset are ignored.

## Timing
- Read latency is 1 cycle from accept edge to `rsp_valid`.
- Throughput is 1 fetch/cycle while `rsp_ready` stays high.
- A write at edge N is visible to a fetch accepted at edge N+1 or later. There is no same-cycle bypass, because fetch and write are mutually exclusive.
- The first accept is possible in the first cycle after `reset` deasserts with `prog_en` low.
- `req_ready` is combinational from `rsp_valid`, `rsp_ready`, `flush`, `prog_en` and `reset`; there is no path from `req_addr`.

## Configuration
- `IMEM_FAULT_EN` defined:
  - An accepted request with `req_addr[1:0]!=0` or `req_addr >= DEPTH*4` responds `rsp_data=NOP`, `rsp_fault=1`.
  - The array is not read for that request.
  - `rsp_fault` follows the same hold/flush/reset rules as `rsp_data`.
- `IMEM_FAULT_EN` undefined:
  - `rsp_fault` is tied 0.
  - Low address bits are ignored and upper bits truncated, so addresses wrap modulo `DEPTH*4`.

## Structure
- Package `imem_pkg` holds:
  - the `NOP` constant;
  - default `DATA_W`/`DEPTH` localparams;
  - a `index_w(DEPTH)` helper constant function.
- Sub-module `imem_array`: `DEPTH x DATA_W` storage with one synchronous write port and one synchronous read port, plus enable. It is `NOP`-initialised and inferable as block RAM.
- The top level contains the handshake, flush and fault logic and the response register.

## Test plan
- Reset, then program words 0..3 with 32'h02328020, 32'h00000093, 32'h00100113, 32'h002081B3 via `prog_en`; fetch 0x0, 0x4, 0x8, 0xC back-to-back with `rsp_ready=1` → one response per cycle in order, latency 1.
- Fetch 0x4 with `rsp_ready=0` for 3 cycles → `rsp_data=32'h00000093` held; `req_ready=0` until the handshake.
- Pending response plus `flush=1` → `rsp_valid=0` next cycle, `rsp_data=NOP`; the request presented during flush is not accepted.
- Raise `prog_en` with a response pending, write index 1 = 32'hDEADBEEF → pending data unchanged; after `prog_en` falls, fetch 0x4 returns 32'hDEADBEEF.
- With `IMEM_FAULT_EN`, fetch 0x2 and `DEPTH*4` → `rsp_fault=1`, `rsp_data=NOP`. Without it, fetch `DEPTH*4` → returns word 0, `rsp_fault=0`.
- Assert `reset` mid-stream with `rsp_valid=1` → all outputs take their reset values next cycle, and memory contents are retained.
